pipelined_cs_addsub: RTL
========================

PIPELINED_CS_ADDSUB -- requirements
Module: pipelined_cs_addsub

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width; legal values 4, 8, 16, 32, 64 (power of two).
REQ-002 SHALL have parameter LEVELS, default 3, number of conditional-sum merge levels; SHALL equal log2(WIDTH), elaboration error otherwise.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  operand set present.
REQ-006 SHALL have port in_ready  output  1  block accepts operand set this cycle.
REQ-007 SHALL have port x  input  WIDTH  operand A.
REQ-008 SHALL have port y  input  WIDTH  operand B.
REQ-009 SHALL have port mode  input  1  0 = add, 1 = subtract (y inverted bitwise).
REQ-010 SHALL have port cin  input  1  carry into bit 0.
REQ-011 SHALL have port out_valid  output  1  result present.
REQ-012 SHALL have port out_ready  input  1  consumer takes result this cycle.
REQ-013 SHALL have port sum  output  WIDTH  result.
REQ-014 SHALL have port cout  output  1  carry out of MSB.
REQ-015 SHALL have port ovf  output  1  two's-complement signed overflow.
REQ-016 SHALL have port zero  output  1  sum == 0.
REQ-017 SHALL have port busy  output  1  any pipeline stage holds a valid entry.

Function
REQ-018 SHALL compute {cout,sum} = x + (y XOR {WIDTH{mode}}) + cin, modulo 2^(WIDTH+1); true subtraction x-y requires mode=1, cin=1.
REQ-019 SHALL use conditional-sum structure: stage 0 forms per-bit sum/carry pairs for carry-in 0 and 1; each merge level k doubles group size 2^k -> 2^(k+1), upper group selecting its carry-0/carry-1 pair by the lower group's carry; final select by cin.
REQ-020 SHALL register stage 0 output and each merge level output: LEVELS+1 pipeline stages, each with its own valid bit.
REQ-021 SHALL carry cin, and sign bits x[WIDTH-1], (y^mode)[WIDTH-1], alongside data through every stage.
REQ-022 SHALL have latency exactly LEVELS+1 cycles from accepting edge (in_valid & in_ready) to out_valid high, with no stalls.
REQ-023 SHALL define advance = !out_valid | out_ready; all stages shift one position on advance, hold otherwise (global stall).
REQ-024 SHALL drive in_ready = advance; an input with in_valid low on an advancing edge inserts a bubble (valid 0).
REQ-025 SHALL sustain one result per cycle while out_ready stays high.
REQ-026 SHALL hold sum, cout, ovf, zero, out_valid stable while out_valid & !out_ready.
REQ-027 SHALL compute ovf = (sign_x == sign_yt) & (sum[WIDTH-1] != sign_x), registered with the result.
REQ-028 SHALL compute zero from the final-stage sum only, registered with the result; cout does not affect zero.
REQ-029 SHALL drive busy = OR of all stage valid bits.
REQ-030 SHALL ignore x, y, mode, cin when in_valid or in_ready is low.

Reset
REQ-031 SHALL, on reset high, asynchronously clear every stage valid bit, out_valid, busy to 0, and sum, cout, ovf, zero to 0.
REQ-032 SHALL drive in_ready = 1 while reset is high and afterwards until stalled.
REQ-033 SHALL discard all in-flight operations on reset mid-operation; no result from before reset appears afterwards.
REQ-034 SHALL accept a new operand on the first rising edge after reset deasserts.

Verification (WIDTH=8, LEVELS=3, latency 4)
REQ-035 SHALL pass: x=0x7F, y=0x01, mode=0, cin=0, out_ready=1 -> 4 cycles later out_valid=1, sum=0x80, cout=0, ovf=1, zero=0.
REQ-036 SHALL pass: x=0x05, y=0x05, mode=1, cin=1 -> sum=0x00, cout=1, ovf=0, zero=1; x=0xFF, y=0x01, mode=0, cin=0 -> sum=0x00, cout=1, ovf=0, zero=1.
REQ-037 SHALL pass: 16 back-to-back random operands, out_ready=1 -> 16 consecutive out_valid cycles, in-order results matching REQ-018 reference model, busy falls 4 cycles after last accept.
REQ-038 SHALL pass: pipeline full, out_ready=0 for 5 cycles -> in_ready=0, outputs frozen; out_ready=1 -> remaining results drain in order, none lost or duplicated.
REQ-039 SHALL pass: reset pulsed with 3 operations in flight -> out_valid, busy, sum=0 immediately; no stale result in next 8 cycles.
REQ-040 SHALL pass: exhaustive 8-bit x, y, mode, cin sweep with random out_ready toggling -> every result matches model, including ovf at 0x80-0x01 (mode=1, cin=1: sum=0x7F, ovf=1).

Source files
------------

// File: rtl/pipelined_cs_addsub.sv
// pipelined_cs_addsub: conditional-sum add/subtract, LEVELS+1 register stages under a global stall
module pipelined_cs_addsub #(
  parameter int WIDTH  = 8,
  parameter int LEVELS = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             mode,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             busy
);
  if ((1 << LEVELS) != WIDTH || WIDTH < 4) begin : g_bad
    $error("pipelined_cs_addsub: WIDTH must be a power of two >= 4 and LEVELS = log2(WIDTH)");
  end
  logic [LEVELS:0]                r_v;
  logic [LEVELS-1:0][WIDTH-1:0]   r_s0, r_s1;
  logic [LEVELS-1:0][WIDTH-1:0]   w_s0, w_s1;
  logic [2*WIDTH-3:0]             r_c0, r_c1;
  logic [WIDTH-2:0]               w_c0, w_c1;
  logic [LEVELS-1:0]              r_ci, r_sx, r_sy;
  logic [WIDTH-1:0]               w_yt, w_sum, r_sum;
  logic                           w_adv, w_co, r_co, r_ovf, r_zero;
  assign w_yt  = y ^ {WIDTH{mode}};
  assign w_adv = !r_v[LEVELS] | out_ready;
  // r_c packs per-stage group carries: stage k (W>>k groups) starts at 2W - (2W>>k)
  for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
    localparam int G  = 1 << k;
    localparam int CI = 2 * WIDTH - ((2 * WIDTH) >> k);
    localparam int CO = WIDTH - ((2 * WIDTH) >> (k + 1));
    for (genvar i = 0; i < (WIDTH >> (k + 1)); i++) begin : g_grp
      localparam int B = 2 * G * i;
      logic w_l0, w_l1;
      assign w_l0 = r_c0[CI+2*i];
      assign w_l1 = r_c1[CI+2*i];
      assign w_s0[k][B +: G]   = r_s0[k][B +: G];
      assign w_s1[k][B +: G]   = r_s1[k][B +: G];
      assign w_s0[k][B+G +: G] = w_l0 ? r_s1[k][B+G +: G] : r_s0[k][B+G +: G];
      assign w_s1[k][B+G +: G] = w_l1 ? r_s1[k][B+G +: G] : r_s0[k][B+G +: G];
      assign w_c0[CO+i] = w_l0 ? r_c1[CI+2*i+1] : r_c0[CI+2*i+1];
      assign w_c1[CO+i] = w_l1 ? r_c1[CI+2*i+1] : r_c0[CI+2*i+1];
    end
  end
  assign w_sum = r_ci[LEVELS-1] ? w_s1[LEVELS-1] : w_s0[LEVELS-1];
  assign w_co  = r_ci[LEVELS-1] ? w_c1[WIDTH-2] : w_c0[WIDTH-2];
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_v    <= '0;
      r_s0   <= '0;
      r_s1   <= '0;
      r_c0   <= '0;
      r_c1   <= '0;
      r_ci   <= '0;
      r_sx   <= '0;
      r_sy   <= '0;
      r_sum  <= '0;
      r_co   <= 1'b0;
      r_ovf  <= 1'b0;
      r_zero <= 1'b0;
    end else if (w_adv) begin
      r_v                     <= {r_v[LEVELS-1:0], in_valid};
      r_s0[0]                 <= x ^ w_yt;
      r_s1[0]                 <= ~(x ^ w_yt);
      r_c0[WIDTH-1:0]         <= x & w_yt;
      r_c1[WIDTH-1:0]         <= x | w_yt;
      for (int j = 1; j < LEVELS; j++) begin
        r_s0[j] <= w_s0[j-1];
        r_s1[j] <= w_s1[j-1];
      end
      r_c0[2*WIDTH-3:WIDTH]   <= w_c0[WIDTH-3:0];
      r_c1[2*WIDTH-3:WIDTH]   <= w_c1[WIDTH-3:0];
      r_ci                    <= {r_ci[LEVELS-2:0], cin};
      r_sx                    <= {r_sx[LEVELS-2:0], x[WIDTH-1]};
      r_sy                    <= {r_sy[LEVELS-2:0], w_yt[WIDTH-1]};
      if (r_v[LEVELS-1]) begin
        r_sum  <= w_sum;
        r_co   <= w_co;
        r_ovf  <= (r_sx[LEVELS-1] == r_sy[LEVELS-1]) & (w_sum[WIDTH-1] != r_sx[LEVELS-1]);
        r_zero <= ~|w_sum;
      end
    end
  assign in_ready  = w_adv;
  assign out_valid = r_v[LEVELS];
  assign busy      = |r_v;
  assign sum       = r_sum;
  assign cout      = r_co;
  assign ovf       = r_ovf;
  assign zero      = r_zero;
endmodule
